// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel edge pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_GX  = 2'd0,
    MODE_GY  = 2'd1,
    MODE_SUM = 2'd2,
    MODE_MAX = 2'd3
  } sobel_mode_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sobel_state_t;

  // Width of a counter that holds 0..n-1; never narrower than one bit.
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Two-stage Sobel arithmetic: weighted tap sums, then abs/select/saturate/border.
// The threshold comparator exists only when SOBEL_THRESH_EN is defined.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_p0,
  input  logic [PIX_W-1:0] p00,
  input  logic [PIX_W-1:0] p01,
  input  logic [PIX_W-1:0] p02,
  input  logic [PIX_W-1:0] p10,
  input  logic [PIX_W-1:0] p12,
  input  logic [PIX_W-1:0] p20,
  input  logic [PIX_W-1:0] p21,
  input  logic [PIX_W-1:0] p22,
  input  logic             vld_p1,
  input  logic [1:0]       mode_p1,
  input  logic             border_p1,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
  output logic             edge_p2,
`endif
  output logic [PIX_W-1:0] mag_p2
);

  localparam int SW = PIX_W + 2;
  localparam int MW = PIX_W + 3;
  localparam logic [MW-1:0] SAT_MAX = {3'b000, {PIX_W{1'b1}}};

  function automatic logic [SW-1:0] tap_sum(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return SW'(a) + {1'b0, b, 1'b0} + SW'(c);
  endfunction

  function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] a,
                                             input logic [SW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [PIX_W-1:0] saturate(input logic [MW-1:0] v);
    return (v > SAT_MAX) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
  endfunction

  logic [SW-1:0]    sum_l_p1, sum_r_p1, sum_t_p1, sum_b_p1;
  logic [SW-1:0]    gx, gy;
  logic [MW-1:0]    raw;
  logic [PIX_W-1:0] mag;

  // ---- stage p0 -> p1: column and row weighted sums
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sum_l_p1 <= tap_sum(p00, p10, p20);
      sum_r_p1 <= tap_sum(p02, p12, p22);
      sum_t_p1 <= tap_sum(p00, p01, p02);
      sum_b_p1 <= tap_sum(p20, p21, p22);
    end
  end

  // ---- stage p1 -> p2: gradient magnitudes, mode select, saturate, border force
  always_comb begin
    gx  = abs_diff(sum_r_p1, sum_l_p1);
    gy  = abs_diff(sum_b_p1, sum_t_p1);
    raw = '0;
    case (sobel_mode_t'(mode_p1))
      MODE_GX:  raw = MW'(gx);
      MODE_GY:  raw = MW'(gy);
      MODE_SUM: raw = MW'(gx) + MW'(gy);
      default:  raw = MW'((gx > gy) ? gx : gy);
    endcase
    mag = border_p1 ? '0 : saturate(raw);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_p2 <= '0;
    end else if (vld_p1) begin
      mag_p2 <= mag;
    end
  end

`ifdef SOBEL_THRESH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_p2 <= 1'b0;
    end else if (vld_p1) begin
      edge_p2 <= !border_p1 && (mag >= thresh);
    end
  end
`endif

endmodule

// File: rtl/sobel_edge_pipe.sv
// 3x3 Sobel edge stage: pixel window, column tracking and per-line flush FSM.
// Define SOBEL_THRESH_EN to add the thresh input and registered out_edge flag.
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int IMG_W = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] row0_pix,
  input  logic [PIX_W-1:0] row1_pix,
  input  logic [PIX_W-1:0] row2_pix,
  input  logic [1:0]       mode,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
  output logic             out_edge,
`endif
  output logic [PIX_W-1:0] out_pix,
  output logic             out_valid,
  output logic             out_border
);

  localparam int COL_W = col_w(IMG_W);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(0);
  localparam logic [COL_W-1:0] EDGE_COL  = COL_W'(1);

  sobel_state_t          state, state_next;
  logic [COL_W-1:0]      col;
  logic                  accept, flush, shift, ready_next;
  logic [8:0][PIX_W-1:0] win_p0;   // index row*3 + col; col 0 holds the newest pixel
  logic                  vld_p0, border_p0;
  sobel_mode_t           mode_p0;
  logic                  vld_p1, border_p1;
  sobel_mode_t           mode_p1;

  assign accept = in_valid && in_ready;
  assign shift  = accept || flush;

  always_comb begin
    state_next = state;
    flush      = 1'b0;
    case (state)
      RUN: begin
        if (accept && (col == LAST_COL)) state_next = FLUSH;
      end
      FLUSH: begin
        flush      = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    ready_next = (state_next == RUN);
  end

  // in_ready is registered so that it stays low for the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      in_ready <= 1'b0;
      col      <= '0;
    end else begin
      state    <= state_next;
      in_ready <= ready_next;
      if (accept) col <= (col == LAST_COL) ? '0 : col + 1'b1;
    end
  end

  // ---- stage p0: window shift plus the sideband issued with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_p0 <= '0;
    end else if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win_p0[r*3+2] <= win_p0[r*3+1];
        win_p0[r*3+1] <= win_p0[r*3];
      end
      win_p0[0] <= flush ? '0 : row0_pix;
      win_p0[3] <= flush ? '0 : row1_pix;
      win_p0[6] <= flush ? '0 : row2_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      border_p0 <= 1'b0;
      mode_p0   <= MODE_GX;
    end else begin
      vld_p0    <= flush || (accept && (col != FIRST_COL));
      border_p0 <= flush || (accept && (col == EDGE_COL));
      if (accept) mode_p0 <= sobel_mode_t'(mode);
    end
  end

  // ---- stage p1 / p2: sideband follows the kernel's two registered stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      border_p1  <= 1'b0;
      mode_p1    <= MODE_GX;
      out_valid  <= 1'b0;
      out_border <= 1'b0;
    end else begin
      vld_p1     <= vld_p0;
      border_p1  <= border_p0;
      mode_p1    <= mode_p0;
      out_valid  <= vld_p1;
      out_border <= vld_p1 && border_p1;
    end
  end

  sobel_kernel #(
    .PIX_W(PIX_W)
  ) kernel (
    .clk      (clk),
    .rst      (rst),
    .vld_p0   (vld_p0),
    .p00      (win_p0[0]),
    .p01      (win_p0[1]),
    .p02      (win_p0[2]),
    .p10      (win_p0[3]),
    .p12      (win_p0[5]),
    .p20      (win_p0[6]),
    .p21      (win_p0[7]),
    .p22      (win_p0[8]),
    .vld_p1   (vld_p1),
    .mode_p1  (mode_p1),
    .border_p1(border_p1),
`ifdef SOBEL_THRESH_EN
    .thresh   (thresh),
    .edge_p2  (out_edge),
`endif
    .mag_p2   (out_pix)
  );

endmodule

// File: doc/sobel_edge_pipe.md
# sobel_edge_pipe

Parametrised successor to the fixed 12-bit 3x3 Sobel stage. It takes three vertically aligned pixel streams from the line buffers and holds a 3x3 window that advances only on accepted pixels. Border columns are tracked per line, and the block emits exactly one saturated edge magnitude per image column through a 3-cycle arithmetic pipeline. It sits between the line-buffer block and the output/threshold stage.

## Interface
- PIX_W, 12, pixel width (bits); output width equals PIX_W
- IMG_W, 640, pixels per line; minimum 3
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  row pixels valid this cycle
- in_ready  out  1  block accepts pixels; accept = in_valid && in_ready
- row0_pix / row1_pix / row2_pix  in  PIX_W each  top / middle / bottom row pixel, same column
- mode  in  2  0 = |Gx| vertical edges, 1 = |Gy| horizontal edges, 2 = |Gx|+|Gy|, 3 = max(|Gx|,|Gy|)
- out_pix  out  PIX_W  edge magnitude
- out_valid  out  1  out_pix valid; single-cycle pulse per column, no backpressure
- out_border  out  1  out_pix belongs to image column 0 or IMG_W-1
- thresh  in  PIX_W  edge threshold; present only with SOBEL_THRESH_EN
- out_edge  out  1  out_pix >= thresh; present only with SOBEL_THRESH_EN

## Operation
- Reset values, asynchronous on rst high:
  - window all zero, col = 0, state RUN
  - in_ready = 0, out_pix = 0, out_valid = 0, out_border = 0, out_edge = 0
  - in_ready rises on the first clk edge after rst falls
- Window update:
  - on accept, each row shifts right; new pixels enter column 0
  - with no accept, the window holds (unlike the predecessor, which shifted every clock)
- col counter (0..IMG_W-1) holds the column index of the next accepted pixel; it wraps to 0 after IMG_W-1.
- Output for each accept:
  - accept at col k >= 1 issues an output for centre column k-1
  - accept at col 0 issues nothing
- State machine:
  - RUN: in_ready = 1. Accepting col IMG_W-1 moves to FLUSH and clears in_ready.
  - FLUSH (exactly one cycle): in_ready = 0; zeros shift into window column 0; an output for centre column IMG_W-1 is issued; return to RUN with in_ready = 1.
  - Each line therefore yields exactly IMG_W outputs and costs IMG_W+1 cycles minimum.
- Arithmetic (all unsigned, no truncation):
  - column sums L = p00 + 2*p10 + p20 and R = p02 + 2*p12 + p22: PIX_W+2 bits
  - row sums T = p00 + 2*p01 + p02 and B = p20 + 2*p21 + p22: PIX_W+2 bits
  - |Gx| = |R-L| and |Gy| = |B-T|
  - mode 2 sum uses PIX_W+3 bits
  - the selected result saturates to 2^PIX_W - 1 (the predecessor truncated)
- Border: centre columns 0 and IMG_W-1 force out_pix = 0 and out_border = 1, independent of mode.
- mode is sampled at accept time and travels with its pixel. A mid-line change affects only later-accepted pixels; in-flight results are unchanged.
- Reset mid-line: pipeline contents are discarded and the next accepted pixel is column 0.

## Timing
- Pipeline:
  - cycle n: accept (or FLUSH); window registered at the end of n
  - end of n+1: L/R/T/B sums registered
  - end of n+2: abs, select, saturate, border force, threshold registered
  - cycle n+3: out_valid visible
- Latency is 3 cycles from presentation to out_valid.
- Throughput is one output per cycle, except one in_ready-low cycle per line.
- in_valid while in_ready = 0 is ignored; the source must hold its pixels.
- Back-to-back lines: col 0 of the next line is accepted in the cycle after FLUSH.

## Configuration
- SOBEL_THRESH_EN defined:
  - thresh and out_edge ports exist
  - out_edge is registered in the same stage as out_pix, so it has the same latency
  - out_edge is 0 on border columns
- SOBEL_THRESH_EN undefined: no ports, no comparator; all other behaviour is identical.

## Structure
- sobel_pkg holds:
  - typedef enum sobel_mode_t {MODE_GX, MODE_GY, MODE_SUM, MODE_MAX}
  - typedef enum sobel_state_t {RUN, FLUSH}
  - function clog2-based COL_W
- One sub-module, sobel_kernel: the two-stage registered arithmetic (sums → abs/select/saturate), parametrised by PIX_W.
- The top level owns the window, col counter, FSM and sideband pipeline (valid, border, mode).

## Test plan
- Flat image, IMG_W=4, all pixels 100, mode 0, continuous in_valid:
  - 4 outputs per line, all 0
  - out_border pattern 1,0,0,1
  - in_ready low exactly one cycle after the 4th accept
- Vertical step (left columns 0, right columns 200), PIX_W=12, mode 0:
  - interior out_pix = 800
  - mode 1 on the same data gives 0
- Saturation: PIX_W=8, left 0 / right 255, all rows, mode 2 → interior 255 (raw 1020 clipped).
- Gapped input: in_valid pattern 1,0,0,1,1,0,1 → outputs match gap-free values; each out_valid exactly 3 cycles after its accept.
- rst pulsed after 2 accepts of a line:
  - all outputs 0 within the same cycle
  - the next line starts at column 0 with correct border flags
- SOBEL_THRESH_EN, thresh = 400, step image above → out_edge = 1 on interior step columns, 0 elsewhere.
